// File: rtl/mdu_if.sv
// MDU request/result bundle.
//   start  : one-cycle request strobe from the E stage
//   MDUop  : operation code (NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MADD/MADDU)
//   A, B   : forwarded rs / rt operands
//   busy   : operation in flight; controller stalls MDU instructions while high
//   HI, LO : architectural HI/LO registers
// master = pipeline/controller side, slave = MDU side.
interface mdu_if;
  logic        start;
  logic [3:0]  MDUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, output MDUop, output A, output B,
                  input busy, input HI, input LO);
  modport slave  (input start, input MDUop, input A, input B,
                  output busy, output HI, output LO);
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// The result is computed at the start edge and held in temp registers; HI/LO
// are written when the 5-cycle (multiply) or 10-cycle (divide) countdown
// expires. MTHI/MTLO write immediately with no busy cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mdu_if.slave (start, MDUop, A, B in; busy, HI, LO out)
// Build option: define MDU_MADD_EN to enable MADD/MADDU (accumulate into
// {HI,LO}); otherwise opcodes 7/8 behave as NONE.
module mdu (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8
  } op_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] hi_q, lo_q, temp_hi, temp_lo;
  logic        temp_wr;   // cleared for divide-by-zero so completion leaves HI/LO alone

  op_t         op;
  logic        is_mul, is_div, is_mthi, is_mtlo, res_wr;
  logic [63:0] res, prod_u, prod_s;
  logic [31:0] div_b, quo_s, rem_s, quo_u, rem_u;
  logic signed [31:0] sa, sb;

  // Operand datapath; a zero divisor is replaced by 1 only to keep the
  // divider defined, the result is discarded via res_wr.
  always_comb begin
    prod_u = {32'h0, bus.A} * {32'h0, bus.B};
    prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    div_b  = (bus.B == '0) ? 32'd1 : bus.B;
    sa     = bus.A;
    sb     = div_b;
    quo_s  = sa / sb;
    rem_s  = sa % sb;
    quo_u  = bus.A / div_b;
    rem_u  = bus.A % div_b;
  end

  // Opcode decode and result selection
  always_comb begin
    op      = op_t'(bus.MDUop);
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    res_wr  = 1'b1;
    res     = '0;
    case (op)
      OP_MULT:  begin is_mul = 1'b1; res = prod_s; end
      OP_MULTU: begin is_mul = 1'b1; res = prod_u; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; res = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin is_mul = 1'b1; res = {hi_q, lo_q} + prod_u; end
`endif
      OP_DIV:   begin is_div = 1'b1; res = {rem_s, quo_s}; res_wr = (bus.B != '0); end
      OP_DIVU:  begin is_div = 1'b1; res = {rem_u, quo_u}; res_wr = (bus.B != '0); end
      OP_MTHI:  is_mthi = 1'b1;
      OP_MTLO:  is_mtlo = 1'b1;
      default:  ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start && (is_mul || is_div)) state_nx = RUN;
      RUN:  if (cnt == 4'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = (state == RUN);
    bus.HI   = hi_q;
    bus.LO   = lo_q;
  end

  // Counter, temp and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      temp_wr <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_mul || is_div) begin
              cnt     <= is_mul ? 4'd5 : 4'd10;
              temp_hi <= res[63:32];
              temp_lo <= res[31:0];
              temp_wr <= res_wr;
            end
            if (is_mthi) hi_q <= bus.A;
            if (is_mtlo) lo_q <= bus.A;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1 && temp_wr) begin
            hi_q <= temp_hi;
            lo_q <= temp_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
